// File: rtl/sprite_defs.sv
// sprite_defs: shared definitions for the sprite blitter slice.
//   - FSM state encoding for sprite_blitter
//   - clog2 helper (never returns less than 1, so index ports stay legal)
//   - default sprite geometry constants
package sprite_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_N_CH  = 4;
  localparam int unsigned DEF_SPR_W = 5;
  localparam int unsigned DEF_SPR_H = 5;
  localparam int unsigned DEF_CELL  = 5;
  localparam int unsigned DEF_COL_W = 3;
  localparam int unsigned DEF_GX_W  = 5;
  localparam int unsigned DEF_GY_W  = 5;
  localparam int unsigned DEF_XW    = 8;
  localparam int unsigned DEF_YW    = 7;

  // Ceiling log2, minimum 1 bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) res = i + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/sprite_pixel_counter.sv
// sprite_pixel_counter: column/row sweep counter for a W x H sprite.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   enable         : advance one pixel (column first, row on column wrap)
//   clear          : synchronous return to (0,0), overrides enable
//   c, r           : current column / row
//   last           : high while at (W-1, H-1)
module sprite_pixel_counter
  import sprite_defs::*;
#(
  parameter int unsigned W = DEF_SPR_W,
  parameter int unsigned H = DEF_SPR_H
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                clear,
  output logic [clog2(W)-1:0] c,
  output logic [clog2(H)-1:0] r,
  output logic                last
);

  localparam int unsigned CB = clog2(W);
  localparam int unsigned RB = clog2(H);

  logic c_wrap;
  logic r_wrap;

  assign c_wrap = (c == CB'(W - 1));
  assign r_wrap = (r == RB'(H - 1));
  assign last   = c_wrap && r_wrap;

  // Wrapping at the last pixel lands back on (0,0), so back-to-back passes need no clear.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      c <= '0;
      r <= '0;
    end else if (enable) begin
      if (c_wrap) begin
        c <= '0;
        r <= r_wrap ? '0 : r + RB'(1);
      end else begin
        c <= c + CB'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: round-robin multi-channel sprite renderer feeding vga_adapter.
// For a granted channel it erases the previously drawn footprint (if any), then
// draws the new bitmap one pixel per clock; hide erases without redrawing.
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   req, hide               : per-channel request level / erase-only flag
//   gx, gy, shape, colour   : per-channel packed slices (channel k in slice k)
//   ack                     : one-hot grant pulse (grant cycle)
//   busy, done, done_ch     : pass in progress / completion pulse and channel
//   x, y, col_out, plot     : pixel write port, combinational from state/counters
module sprite_blitter
  import sprite_defs::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned SPR_W       = DEF_SPR_W,
  parameter int unsigned SPR_H       = DEF_SPR_H,
  parameter int unsigned CELL        = DEF_CELL,
  parameter int unsigned COL_W       = DEF_COL_W,
  parameter int unsigned GX_W        = DEF_GX_W,
  parameter int unsigned GY_W        = DEF_GY_W,
  parameter int unsigned XW          = DEF_XW,
  parameter int unsigned YW          = DEF_YW,
  parameter int unsigned BG          = 0,
  parameter int unsigned TRANSPARENT = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [N_CH-1:0]                req,
  input  logic [N_CH-1:0]                hide,
  input  logic [N_CH*GX_W-1:0]           gx,
  input  logic [N_CH*GY_W-1:0]           gy,
  input  logic [N_CH*SPR_W*SPR_H-1:0]    shape,
  input  logic [N_CH*COL_W-1:0]          colour,
  output logic [N_CH-1:0]                ack,
  output logic                           busy,
  output logic                           done,
  output logic [clog2(N_CH)-1:0]         done_ch,
  output logic [XW-1:0]                  x,
  output logic [YW-1:0]                  y,
  output logic [COL_W-1:0]               col_out,
  output logic                           plot
);

  localparam int unsigned P   = SPR_W * SPR_H;
  localparam int unsigned CHW = clog2(N_CH);
  localparam int unsigned CB  = clog2(SPR_W);
  localparam int unsigned RB  = clog2(SPR_H);
  localparam int unsigned IW  = clog2(P);

  state_t state, state_n;

  logic [CHW-1:0]   rr_ptr;
  logic [CHW-1:0]   ch_q;
  logic [N_CH-1:0]  prev_valid;
  logic [XW-1:0]    prev_x [N_CH];
  logic [YW-1:0]    prev_y [N_CH];

  logic [XW-1:0]    base_x;
  logic [YW-1:0]    base_y;
  logic [P-1:0]     shape_q;
  logic [COL_W-1:0] colour_q;
  logic             hide_q;

  logic [GX_W-1:0]  gx_a     [N_CH];
  logic [GY_W-1:0]  gy_a     [N_CH];
  logic [P-1:0]     shape_a  [N_CH];
  logic [COL_W-1:0] colour_a [N_CH];

  logic             grant_valid;
  logic             grant_fire;
  logic [CHW-1:0]   grant_ch;

  logic             cnt_en;
  logic             cnt_clr;
  logic [CB-1:0]    cnt_c;
  logic [RB-1:0]    cnt_r;
  logic             cnt_last;
  logic [IW-1:0]    pix_idx;
  logic             pix_bit;

  // Unpack per-channel slices.
  for (genvar k = 0; k < N_CH; k++) begin : g_slice
    assign gx_a[k]     = gx[k*GX_W +: GX_W];
    assign gy_a[k]     = gy[k*GY_W +: GY_W];
    assign shape_a[k]  = shape[k*P +: P];
    assign colour_a[k] = colour[k*COL_W +: COL_W];
  end

  sprite_pixel_counter #(
    .W (SPR_W),
    .H (SPR_H)
  ) u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (cnt_en),
    .clear   (cnt_clr),
    .c       (cnt_c),
    .r       (cnt_r),
    .last    (cnt_last)
  );

  // Round-robin: first requester strictly after rr_ptr, wrapping; held off during reset.
  always_comb begin
    logic           found;
    logic [CHW-1:0] cand;
    found    = 1'b0;
    cand     = '0;
    grant_ch = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      cand = CHW'((32'(rr_ptr) + i) % N_CH);
      if (!found && req[cand]) begin
        found    = 1'b1;
        grant_ch = cand;
      end
    end
    grant_valid = found && reset_n;
  end

  assign grant_fire = (state == ST_IDLE) && grant_valid;

  // Bitmap is row-major from the MSB.
  assign pix_idx = IW'(P - 1 - (32'(cnt_r) * SPR_W + 32'(cnt_c)));
  assign pix_bit = shape_q[pix_idx];

  // Control state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= CHW'(N_CH - 1);
      ch_q       <= '0;
      prev_valid <= '0;
    end else begin
      state <= state_n;
      if (grant_fire) begin
        rr_ptr <= grant_ch;
        ch_q   <= grant_ch;
      end
      if (state == ST_DONE) prev_valid[ch_q] <= !hide_q;
    end
  end

  // Grant-time latches (origin multiply done once here) and footprint history.
  always_ff @(posedge clock) begin
    if (grant_fire) begin
      base_x   <= XW'(32'(gx_a[grant_ch]) * CELL);
      base_y   <= YW'(32'(gy_a[grant_ch]) * CELL);
      shape_q  <= shape_a[grant_ch];
      colour_q <= colour_a[grant_ch];
      hide_q   <= hide[grant_ch];
    end
    if (state == ST_DONE && !hide_q) begin
      prev_x[ch_q] <= base_x;
      prev_y[ch_q] <= base_y;
    end
  end

  // Next state and pixel/handshake outputs.
  always_comb begin
    state_n = state;
    ack     = '0;
    busy    = 1'b0;
    done    = 1'b0;
    done_ch = '0;
    x       = '0;
    y       = '0;
    col_out = '0;
    plot    = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (grant_valid) begin
          ack[grant_ch] = 1'b1;
          if (prev_valid[grant_ch])  state_n = ST_ERASE;
          else if (hide[grant_ch])   state_n = ST_DONE;
          else                       state_n = ST_DRAW;
        end
      end
      ST_ERASE: begin
        busy    = 1'b1;
        cnt_en  = 1'b1;
        plot    = 1'b1;
        col_out = COL_W'(BG);
        x       = prev_x[ch_q] + XW'(cnt_c);
        y       = prev_y[ch_q] + YW'(cnt_r);
        if (cnt_last) state_n = hide_q ? ST_DONE : ST_DRAW;
      end
      ST_DRAW: begin
        busy    = 1'b1;
        cnt_en  = 1'b1;
        x       = base_x + XW'(cnt_c);
        y       = base_y + YW'(cnt_r);
        plot    = pix_bit || (TRANSPARENT == 0);
        col_out = pix_bit ? colour_q : COL_W'(BG);
        if (cnt_last) state_n = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        done_ch = ch_q;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Multi-channel, parametrised sprite renderer between the game-logic controllers (pacman, ghosts) and `vga_adapter`. It replaces the fixed 5x5 single-sprite draw path. Each channel requests a redraw at a grid position, and requests are served round-robin. For the granted sprite, the block erases that channel's previously drawn footprint, then draws the new bitmap one pixel per clock. Transparent draw is optional. A hide operation erases the sprite without redrawing it.

## Interface
Parameters:
- `N_CH`, 4: number of sprite channels
- `SPR_W`, 5: sprite width in pixels
- `SPR_H`, 5: sprite height in pixels
- `CELL`, 5: pixels per grid cell; pixel origin = grid coordinate × `CELL`
- `COL_W`, 3: colour width
- `GX_W`, 5 / `GY_W`, 5: grid coordinate widths
- `XW`, 8 / `YW`, 7: pixel coordinate widths
- `BG`, 0: background colour used by erase passes and by opaque zero bits
- `TRANSPARENT`, 1: 1 means zero bits produce no plot; 0 means zero bits plot `BG`

Ports:
- `clock`  in  1  single clock
- `reset_n`  in  1  synchronous, active-low reset
- `req`  in  `N_CH`  level request per channel; held until `ack`
- `hide`  in  `N_CH`  per channel; 1 = erase only, sampled at grant
- `gx`  in  `N_CH*GX_W`  grid x per channel; channel k occupies slice k
- `gy`  in  `N_CH*GY_W`  grid y per channel
- `shape`  in  `N_CH*SPR_W*SPR_H`  bitmaps; per slice, MSB = top-left, row-major
- `colour`  in  `N_CH*COL_W`  foreground colour per channel
- `ack`  out  `N_CH`  one-cycle one-hot grant pulse
- `busy`  out  1  high from the cycle after grant through the DONE state
- `done`  out  1  one-cycle completion pulse
- `done_ch`  out  `clog2(N_CH)`  channel index; valid while `done` is high
- `x`  out  `XW`  pixel x to `vga_adapter`
- `y`  out  `YW`  pixel y
- `col_out`  out  `COL_W`  pixel colour
- `plot`  out  1  pixel write enable

## Operation
- State machine states: IDLE, ERASE, DRAW, DONE.
- **IDLE**
  - If any `req` bit is high, grant the first requesting channel after `rr_ptr`, scanning upward with wrap.
  - In the grant cycle: pulse `ack[ch]`, and latch the channel's `gx`, `gy`, `shape`, `colour` and `hide`.
  - Next state is ERASE if `prev_valid[ch]`. Otherwise, next state is DRAW, or DONE if `hide` is set.
  - `rr_ptr` is set to `ch`.
- **ERASE**
  - Sweep `SPR_W*SPR_H` pixels at the stored previous position `prev_x[ch]`, `prev_y[ch]`.
  - Every pixel is written with `plot`=1 and `col_out`=`BG`.
  - After the last pixel, go to DRAW, or to DONE if `hide` is set.
- **DRAW**
  - Sweep `SPR_W*SPR_H` pixels at the latched position.
  - A 1 bit plots `colour`.
  - A 0 bit gives `plot`=0 when `TRANSPARENT`=1, otherwise plots `BG`.
- **DONE**, one cycle:
  - pulse `done` and set `done_ch`=`ch`;
  - normal draw: store the latched position into `prev_x[ch]`, `prev_y[ch]` and set `prev_valid[ch]`=1;
  - hide: clear `prev_valid[ch]`;
  - return to IDLE.
- Sweep order:
  - column counter `c` runs 0..`SPR_W`-1, row counter `r` runs 0..`SPR_H`-1;
  - `c` advances every cycle; `r` increments when `c` wraps;
  - both counters reset to 0 at the start of every pass.
- Bitmap index: `shape` bit `SPR_W*SPR_H-1-(r*SPR_W+c)`.
- Pixel arithmetic:
  - `x` = `g_x*CELL + c`, computed at `XW` bits and wrapping modulo 2^`XW`;
  - `y` likewise at `YW` bits;
  - the multiply is performed once at grant and stored.
- Requests arriving while `busy` is high are not lost: `req` is level-sensitive and is re-arbitrated on the next IDLE cycle.
- Two channels that request in the same cycle are served in round-robin order.
- A channel that drops `req` before `ack` is simply not granted.
- `hide` on a channel with `prev_valid`=0 completes with no plotting: grant, then DONE.

## Timing
- Reset state: IDLE, all `prev_valid`=0, `rr_ptr`=`N_CH`-1 (so channel 0 wins the first contention).
- Reset values: `ack`=0, `busy`=0, `done`=0, `done_ch`=0, `x`=0, `y`=0, `col_out`=0, `plot`=0.
- Pixel outputs are combinational from state/counter registers. `plot` is never high outside ERASE and DRAW.
- Latency with grant at cycle t and P=`SPR_W*SPR_H`:
  - erase+draw: ERASE t+1..t+P, DRAW t+P+1..t+2P, `done` at t+2P+1;
  - first draw only: `done` at t+P+1;
  - for 5x5 these are t+51 and t+26.
- Minimum spacing between grants is one IDLE cycle after DONE.
- Reset asserted mid-pass returns the block to IDLE on the next edge and abandons the partial sprite on screen.

## Structure
- Shared package/include `sprite_defs`:
  - state encodings;
  - the `clog2` function;
  - default sprite geometry constants.
- Sub-module `sprite_pixel_counter #(W,H)`: column/row counter with `enable`, synchronous `clear`, and `last` output (high when c=W-1 and r=H-1). It generalises the existing 5x5 counter.
- The top-level holds the arbiter, latches, per-channel `prev_*` arrays and the FSM.

## Test plan
- Default parameters; ch0 `req`, `gx`=2, `gy`=3, `shape`=all ones, `colour`=6 → 25 plots at x 10..14, y 15..19, `col_out`=6; no erase pass; `done` at grant+26 with `done_ch`=0.
- Redraw ch0 at `gx`=3, `gy`=3 → 25 `BG` plots at x 10..14, then 25 colour plots at x 15..19; `done` at grant+51.
- `shape`=25'h1000001, `TRANSPARENT`=1 → exactly two plots, at (r0,c0) and (r4,c4). With `TRANSPARENT`=0 → 25 plots, 23 of them `BG`.
- `req`=4'b1111 held from reset → grants in order 0,1,2,3; drop ch1 after its `ack`, keep the others → next order 2,3,0.
- `hide` on ch2 after a draw → 25 `BG` plots and no draw pass; a following `hide` on ch2 → `done` one cycle after `ack` with no plots.
- `reset_n` low mid-DRAW → next cycle `plot`=0, `busy`=0; `prev_valid` cleared, so the next request skips erase.
